mem_port: RTL and testbench

MEM_PORT -- requirements
Module: mem_port

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_port_ram.sv | 32 +++
 rtl/mem_port.sv | 169 ++++++++++++++++
 tb/tb_mem_port.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the load/store memory port:
// access sizes, port FSM states and exception vector bytes.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam logic [7:0] EXC_VEC_253 = 8'd253;
    localparam logic [7:0] EXC_VEC_254 = 8'd254;
    localparam logic [7:0] EXC_VEC_255 = 8'd255;

    function automatic logic [2:0] size_bytes(input size_e sz);
        case (sz)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_ram.sv
// Byte-wide storage with four byte-lane write enables.
// Lane i maps to byte addr+i and to data bits [31-8i -: 8].
module mem_port_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [7:0] mem [DEPTH] = '{default: 8'h00};

    for (genvar i = 0; i < 4; i++) begin : g_rd
        logic [AW:0] idx;
        assign idx = {1'b0, addr} + (AW+1)'(i);
        // lanes past the top of storage read as zero
        assign rdata[31-8*i -: 8] =
            (idx < (AW+1)'(DEPTH)) ? mem[idx[AW-1:0]] : 8'h00;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr + AW'(i)] <= wdata[31-8*i -: 8];
            end
        end
    end

endmodule

// File: rtl/mem_port.sv
// Single-outstanding CPU load/store port with fixed latency,
// big-endian byte order and alignment/range checking.
module mem_port
    import mem_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        c_we;
    size_e       c_size;
    logic [31:0] c_addr, c_wdata;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        a_we;
    size_e       a_size;
    logic [31:0] a_addr, a_wdata;
    logic [32:0] last_byte;
    logic        a_err;
    logic        accept, access, done;
    logic [3:0]  lane_we;
    logic [31:0] ram_wdata, ram_rdata, load_data;

    // LATENCY=1 accesses at the accept edge, straight from the request
    assign a_we    = (state == IDLE) ? req_we            : c_we;
    assign a_size  = (state == IDLE) ? size_e'(req_size) : c_size;
    assign a_addr  = (state == IDLE) ? req_addr          : c_addr;
    assign a_wdata = (state == IDLE) ? req_wdata         : c_wdata;

    assign last_byte = {1'b0, a_addr}
                     + 33'(size_bytes(a_size)) - 33'd1;

    always_comb begin
        a_err = (last_byte >= 33'(DEPTH));
        case (a_size)
            SZ_BYTE: ;
            SZ_HALF: if (a_addr[0]) a_err = 1'b1;
            SZ_WORD: if (a_addr[1:0] != 2'b00) a_err = 1'b1;
            default: a_err = 1'b1;
        endcase
    end

    always_comb begin
        lane_we   = 4'b0000;
        ram_wdata = 32'h0;
        load_data = 32'h0;
        case (a_size)
            SZ_BYTE: begin
                lane_we   = 4'b0001;
                ram_wdata = {a_wdata[7:0], 24'h0};
                load_data = {24'h0, ram_rdata[31:24]};
            end
            SZ_HALF: begin
                lane_we   = 4'b0011;
                ram_wdata = {a_wdata[15:0], 16'h0};
                load_data = {16'h0, ram_rdata[31:16]};
            end
            SZ_WORD: begin
                lane_we   = 4'b1111;
                ram_wdata = a_wdata;
                load_data = ram_rdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        access  = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY <= 1) begin
                        access  = 1'b1;
                        cnt_n   = 4'd0;
                        state_n = RESP;
                    end else begin
                        cnt_n   = 4'(LATENCY - 1);
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    access  = 1'b1;
                    cnt_n   = 4'd0;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            c_we    <= 1'b0;
            c_size  <= SZ_BYTE;
            c_addr  <= 32'h0;
            c_wdata <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                c_we    <= req_we;
                c_size  <= size_e'(req_size);
                c_addr  <= req_addr;
                c_wdata <= req_wdata;
            end
            if (access) begin
                rdata_q <= (a_we || a_err) ? 32'h0 : load_data;
                err_q   <= a_err;
            end else if (done) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
        end
    end

    mem_port_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .addr  (a_addr[AW-1:0]),
        .we    ((access && a_we && !a_err) ? lane_we : 4'b0000),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_port.sv
// Self-checking bench for mem_port against a byte-array
// reference model with big-endian, range and alignment rules.
module tb_mem_port;
    import mem_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int failures = 0;
    logic [7:0] mdl [DEPTH];

    always #5 clk = ~clk;

    mem_port #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    // Reference: n-byte access, byte at addr is most significant.
    task automatic model(input bit we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output bit err);
        int n;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (sz == 2'd3) || ((a % n) != 0)
           || (longint'(a) + n - 1 >= DEPTH);
        rd = 32'h0;
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                if (we) mdl[int'(a) + i] = wd[8*(n-1-i) +: 8];
                else    rd = (rd << 8) | 32'(mdl[int'(a) + i]);
            end
        end
    endtask

    task automatic xact(input bit we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err,
                        output int lat,
                        output logic [31:0] erd, output bit eerr);
        int n;
        model(we, sz, a, wd, erd, eerr);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_size  = 2'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) lat = -1;
        rd  = rsp_rdata;
        err = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs rdy/vld/err=%b rdata=%h exp 100/0",
                     {req_ready, rsp_valid, rsp_err}, rsp_rdata);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset rdy=%b vld=%b exp 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd, erd;
        logic err;
        bit eerr;
        int lat;
        xact(1, 2'd2, 32'h10, 32'hDEADBEEF, rd, err, lat, erd, eerr);
        checks++;
        if (err !== 1'b0 || rd !== 32'h0 || lat !== LAT) begin
            failures++;
            $display("FAIL st_word err=%b rdata=%h lat=%0d exp 0/0/%0d", err, rd, lat, LAT);
        end
        xact(0, 2'd2, 32'h10, 32'h0, rd, err, lat, erd, eerr);
        checks++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0 || lat !== LAT) begin
            failures++;
            $display("FAIL ld_word rdata=%h err=%b lat=%0d exp deadbeef/0/%0d",
                     rd, err, lat, LAT);
        end
        xact(0, 2'd0, 32'h11, 32'h0, rd, err, lat, erd, eerr);
        checks++;
        if (rd !== 32'h000000AD || err !== 1'b0) begin
            failures++;
            $display("FAIL ld_byte rdata=%h err=%b exp 000000ad/0", rd, err);
        end
        xact(0, 2'd1, 32'h12, 32'h0, rd, err, lat, erd, eerr);
        checks++;
        if (rd !== 32'h0000BEEF || err !== 1'b0) begin
            failures++;
            $display("FAIL ld_half rdata=%h err=%b exp 0000beef/0", rd, err);
        end
        xact(1, 2'd0, 32'h13, 32'hFFFFFF55, rd, err, lat, erd, eerr);
        xact(0, 2'd2, 32'h10, 32'h0, rd, err, lat, erd, eerr);
        checks++;
        if (rd !== 32'hDEADBE55 || err !== 1'b0) begin
            failures++;
            $display("FAIL st_byte_merge rdata=%h err=%b exp deadbe55/0", rd, err);
        end
    endtask

    task automatic test_exc_vec();
        logic [31:0] rd, erd;
        logic [31:0] va [3];
        logic err;
        bit eerr;
        int lat;
        va[0] = 32'(EXC_VEC_253);
        va[1] = 32'(EXC_VEC_254);
        va[2] = 32'(EXC_VEC_255);
        for (int i = 0; i < 3; i++)
            xact(1, 2'd0, va[i], 32'(i + 1), rd, err, lat, erd, eerr);
        for (int i = 0; i < 3; i++) begin
            xact(0, 2'd0, va[i], 32'h0, rd, err, lat, erd, eerr);
            checks++;
            if (rd !== 32'(i + 1) || err !== 1'b0) begin
                failures++;
                $display("FAIL exc_byte a=%0d rdata=%h err=%b exp %h/0",
                         va[i], rd, err, 32'(i + 1));
            end
        end
        xact(0, 2'd2, 32'd252, 32'h0, rd, err, lat, erd, eerr);
        checks++;
        if (rd !== 32'h00010203 || err !== 1'b0) begin
            failures++;
            $display("FAIL exc_word rdata=%h err=%b exp 00010203/0", rd, err);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd;
        logic err;
        bit eerr;
        int lat;
        bit          we [7];
        logic [1:0]  sz [7];
        logic [31:0] ad [7];
        we = '{0, 0, 0, 0, 1, 1, 0};
        sz = '{2, 1, 3, 2, 2, 1, 0};
        ad = '{32'h11, 32'h21, 32'h10, 32'h100, 32'h11, 32'hFF, 32'hFFFFFFFF};
        for (int i = 0; i < 7; i++) begin
            xact(we[i], sz[i], ad[i], 32'hFFFFFFFF, rd, err, lat, erd, eerr);
            checks++;
            if (err !== 1'b1 || rd !== 32'h0 || lat !== LAT) begin
                failures++;
                $display("FAIL err_case%0d err=%b rdata=%h lat=%0d exp 1/0/%0d",
                         i, err, rd, lat, LAT);
            end
        end
        xact(0, 2'd2, 32'h10, 32'h0, rd, err, lat, erd, eerr);
        checks++;
        if (rd !== 32'hDEADBE55 || err !== 1'b0) begin
            failures++;
            $display("FAIL err_no_write_10 rdata=%h exp deadbe55", rd);
        end
        xact(0, 2'd0, 32'hFF, 32'h0, rd, err, lat, erd, eerr);
        checks++;
        if (rd !== 32'h3 || err !== 1'b0) begin
            failures++;
            $display("FAIL err_no_write_ff rdata=%h exp 00000003", rd);
        end
    endtask

    task automatic test_stall();
        logic [31:0] rd, erd;
        logic err;
        bit eerr;
        int lat;
        model(0, 2'd2, 32'h10, 32'h0, erd, eerr);
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_size  = 2'd2;
            req_addr  = 32'h10;
            req_wdata = 32'h0;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== erd || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall%0d vld=%b rdata=%h rdy=%b exp 1/%h/0",
                         i, rsp_valid, rsp_rdata, req_ready, erd);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release vld=%b rdy=%b exp 0/1", rsp_valid, req_ready);
        end
        xact(0, 2'd2, 32'h10, 32'h0, rd, err, lat, erd, eerr);
        checks++;
        if (rd !== erd || err !== 1'b0) begin
            failures++;
            $display("FAIL stall_ignored_store rdata=%h exp %h", rd, erd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] erd1, erd2;
        bit eerr;
        int lat;
        model(0, 2'd0, 32'h11, 32'h0, erd1, eerr);
        model(0, 2'd1, 32'h12, 32'h0, erd2, eerr);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd0;
        req_addr  = 32'h11;
        @(posedge clk);
        #1;
        req_size = 2'd1;
        req_addr = 32'h12;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (rsp_rdata !== erd1 || req_ready !== 1'b0 || lat !== LAT) begin
            failures++;
            $display("FAIL b2b_first rdata=%h rdy=%b lat=%0d exp %h/0/%0d",
                     rsp_rdata, req_ready, lat, erd1, LAT);
        end
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_early_accept rdy=%b vld=%b exp 1/0", req_ready, rsp_valid);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (rsp_rdata !== erd2 || lat !== LAT) begin
            failures++;
            $display("FAIL b2b_second rdata=%h lat=%0d exp %h/%0d", rsp_rdata, lat, erd2, LAT);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd;
        logic err;
        bit eerr;
        int lat;
        xact(1, 2'd2, 32'h20, 32'hCAFE1234, rd, err, lat, erd, eerr);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 32'h20;
        req_wdata = 32'h0BADF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_wait rdy/vld/err=%b rdata=%h exp 100/0",
                     {req_ready, rsp_valid, rsp_err}, rsp_rdata);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        xact(0, 2'd2, 32'h20, 32'h0, rd, err, lat, erd, eerr);
        checks++;
        if (rd !== 32'hCAFE1234 || rd !== erd || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_wait_store rdata=%h exp cafe1234", rd);
        end
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_resp rdy/vld/err=%b rdata=%h exp 100/0",
                     {req_ready, rsp_valid, rsp_err}, rsp_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a;
        logic [1:0] sz;
        logic err;
        bit eerr, we;
        int lat;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 259));
            xact(we, sz, a, $urandom, rd, err, lat, erd, eerr);
            checks++;
            if (rd !== erd || err !== eerr || lat !== LAT) begin
                failures++;
                $display("FAIL rand%0d we=%b sz=%0d a=%h rdata=%h err=%b lat=%0d exp %h/%b/%0d",
                         i, we, sz, a, rd, err, lat, erd, eerr, LAT);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
        test_reset();
        test_directed();
        test_exc_vec();
        test_errors();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
